// File: rtl/wb_avalon_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port among NUM_MASTERS masters.
// Grant is registered and held cyc-to-cyc; a per-beat watchdog errors out hung accesses.
module wb_avalon_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int TIMEOUT     = 1023
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_ni,
   input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
   input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
   input  logic [NUM_MASTERS-1:0]      m_we_i,
   input  logic [NUM_MASTERS-1:0]      m_cyc_i,
   input  logic [NUM_MASTERS-1:0]      m_stb_i,
   input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
   input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
   output logic [DW-1:0]               m_dat_o,
   output logic [NUM_MASTERS-1:0]      m_ack_o,
   output logic [NUM_MASTERS-1:0]      m_err_o,
   output logic [NUM_MASTERS-1:0]      m_rty_o,
   output logic [AW-1:0]               s_adr_o,
   output logic [DW-1:0]               s_dat_o,
   output logic [DW/8-1:0]             s_sel_o,
   output logic                        s_we_o,
   output logic                        s_cyc_o,
   output logic                        s_stb_o,
   output logic [2:0]                  s_cti_o,
   output logic [1:0]                  s_bte_o,
   input  logic [DW-1:0]               s_dat_i,
   input  logic                        s_ack_i,
   input  logic                        s_err_i,
   input  logic                        s_rty_i,
   output logic [NUM_MASTERS-1:0]      gnt_o
);

   localparam int          OW       = $clog2(NUM_MASTERS);
   localparam int          SW       = DW / 8;
   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

   state_t                 state, state_d;
   logic [OW-1:0]          owner, owner_d, last, last_d, winner;
   logic [NUM_MASTERS-1:0] gnt_d;
   logic [15:0]            wd_cnt, wd_d;
   logic                   found, busy, own_cyc, own_stb, term, wd_hit;
   int                     idx;

   // Round-robin search starting just after the previous owner.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = (int'(last) + i) % NUM_MASTERS;
         if (!found && m_cyc_i[OW'(idx)]) begin
            winner = OW'(idx);
            found  = 1'b1;
         end
      end
   end

   assign busy    = (state == BUSY);
   assign own_cyc = m_cyc_i[owner];
   assign own_stb = m_stb_i[owner];
   assign term    = s_ack_i | s_err_i | s_rty_i;

   // Release and a real termination both take precedence over the watchdog.
   assign wd_hit  = (TIMEOUT != 0) && busy && own_cyc && own_stb && !term
                    && (wd_cnt == WD_LIMIT);

   assign s_adr_o = m_adr_i[int'(owner)*AW +: AW];
   assign s_dat_o = m_dat_i[int'(owner)*DW +: DW];
   assign s_sel_o = m_sel_i[int'(owner)*SW +: SW];
   assign s_cti_o = m_cti_i[int'(owner)*3 +: 3];
   assign s_bte_o = m_bte_i[int'(owner)*2 +: 2];
   assign s_cyc_o = busy && own_cyc;
   assign s_stb_o = busy && own_cyc && own_stb && !wd_hit;
   assign s_we_o  = busy && own_cyc && m_we_i[owner];
   assign m_dat_o = s_dat_i;

   always_comb begin
      m_ack_o = '0;
      m_err_o = '0;
      m_rty_o = '0;
      if (busy) begin
         m_ack_o[owner] = s_ack_i;
         m_err_o[owner] = s_err_i | wd_hit;
         m_rty_o[owner] = s_rty_i;
      end
   end

   always_comb begin
      state_d = state;
      owner_d = owner;
      last_d  = last;
      gnt_d   = gnt_o;
      wd_d    = wd_cnt;
      unique case (state)
         IDLE: begin
            wd_d = '0;
            if (found) begin
               owner_d        = winner;
               gnt_d          = '0;
               gnt_d[winner]  = 1'b1;
               state_d        = BUSY;
            end
         end
         BUSY: begin
            if (!own_cyc) begin
               state_d = IDLE;
               last_d  = owner;
               gnt_d   = '0;
               wd_d    = '0;
            end else if (wd_hit) begin
               state_d = ABORT;
               wd_d    = '0;
            end else if ((TIMEOUT != 0) && own_stb && !term) begin
               wd_d = wd_cnt + 16'd1;
            end else begin
               wd_d = '0;
            end
         end
         ABORT: begin
            // Drain: keep the grant until the abandoned cycle is dropped.
            if (!own_cyc) begin
               state_d = IDLE;
               last_d  = owner;
               gnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state  <= IDLE;
         owner  <= '0;
         last   <= OW'(NUM_MASTERS - 1);
         gnt_o  <= '0;
         wd_cnt <= '0;
      end else begin
         state  <= state_d;
         owner  <= owner_d;
         last   <= last_d;
         gnt_o  <= gnt_d;
         wd_cnt <= wd_d;
      end
   end

endmodule

// File: tb/tb_wb_avalon_arbiter.sv
// Scoreboard bench for wb_avalon_arbiter: directed master sequences push expected
// terminations; a negedge monitor pops and compares each one the DUT presents.
module tb_wb_avalon_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] m_adr, m_dat;
   logic [7:0]  m_sel;
   logic [1:0]  m_we, m_cyc, m_stb;
   logic [5:0]  m_cti;
   logic [3:0]  m_bte;
   logic [31:0] m_dat_o, s_adr_o, s_dat_o, s_dat_i;
   logic [1:0]  m_ack_o, m_err_o, m_rty_o, gnt_o, s_bte_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
   logic [2:0]  s_cti_o;

   logic        cyc_m[2], stb_m[2], we_m[2];
   logic [31:0] adr_m[2], wdat_m[2];
   logic [2:0]  cti_m[2];
   logic [31:0] rd_data = 32'h0;
   logic        ack_en = 1'b1, force_ack = 1'b0;

   typedef struct {
      logic [1:0]  ack, err, gnt;
      logic [31:0] adr, rdat, wdat;
      logic [2:0]  cti;
      logic [3:0]  sel;
      logic        stb, we;
   } exp_t;

   exp_t        sb[$];
   logic [1:0]  glog[$];
   int          gaps[$];
   logic [1:0]  prev_gnt = 2'b00;
   int          idle_run = 0;
   int          n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   always_comb begin
      m_adr = {adr_m[1], adr_m[0]};
      m_dat = {wdat_m[1], wdat_m[0]};
      m_sel = {4'h3, 4'hF};
      m_we  = {we_m[1], we_m[0]};
      m_cyc = {cyc_m[1], cyc_m[0]};
      m_stb = {stb_m[1], stb_m[0]};
      m_cti = {cti_m[1], cti_m[0]};
      m_bte = 4'b0000;
   end

   // Zero-wait bridge: acks whenever the granted master strobes, unless stalled.
   assign s_ack_i = force_ack | (ack_en & s_cyc_o & (|(m_stb & gnt_o)));
   assign s_err_i = 1'b0;
   assign s_rty_i = 1'b0;
   assign s_dat_i = rd_data;

   wb_avalon_arbiter #(.NUM_MASTERS(2), .DW(32), .AW(32), .TIMEOUT(4)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .gnt_o(gnt_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic mi, input logic [31:0] a, input logic [31:0] rd,
                       input logic [31:0] wd, input logic [2:0] ct, input logic w,
                       input logic stb, input logic is_err);
      exp_t x;
      x.ack  = is_err ? 2'b00 : (2'b01 << mi);
      x.err  = is_err ? (2'b01 << mi) : 2'b00;
      x.gnt  = 2'b01 << mi;
      x.adr  = a;
      x.rdat = rd;
      x.wdat = wd;
      x.cti  = ct;
      x.sel  = mi ? 4'h3 : 4'hF;
      x.stb  = stb;
      x.we   = w;
      sb.push_back(x);
   endtask

   task automatic wait_gnt(input logic mi);
      int t = 0;
      while (gnt_o[mi] !== 1'b1 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("grant_wait", 64'(gnt_o[mi]), 64'h1);
   endtask

   task automatic run_cycle(input logic mi, input int nb, input logic [31:0] base,
                            input logic w, input logic burst, input logic [31:0] rd_base);
      cyc_m[mi] = 1'b1;
      stb_m[mi] = 1'b1;
      we_m[mi]  = w;
      adr_m[mi] = base;
      cti_m[mi] = burst ? 3'b010 : 3'b000;
      wdat_m[mi] = 32'hA000_0000 | base;
      wait_gnt(mi);
      for (int b = 0; b < nb; b++) begin
         adr_m[mi]  = base + 32'(4 * b);
         wdat_m[mi] = 32'hA000_0000 | adr_m[mi];
         cti_m[mi]  = !burst ? 3'b000 : ((b == nb - 1) ? 3'b111 : 3'b010);
         rd_data    = rd_base + 32'(b);
         push(mi, adr_m[mi], rd_data, wdat_m[mi], cti_m[mi], w, 1'b1, 1'b0);
         @(posedge clk); #1;
      end
      cyc_m[mi] = 1'b0;
      stb_m[mi] = 1'b0;
      cti_m[mi] = 3'b000;
      we_m[mi]  = 1'b0;
      @(posedge clk); #1;
   endtask

   // Monitor: invariants every cycle, grant log, scoreboard pop on any termination.
   always @(negedge clk) begin
      exp_t e;
      logic [1:0] terms;
      terms = m_ack_o | m_err_o | m_rty_o;
      check("gnt_onehot0", 64'($onehot0(gnt_o)), 64'h1);
      check("term_onehot0", 64'($onehot0(terms)), 64'h1);
      check("stb_implies_cyc", 64'(s_stb_o & ~s_cyc_o), 64'h0);
      if (gnt_o != 2'b00 && gnt_o != prev_gnt) begin
         check("grant_from_idle", 64'(prev_gnt), 64'h0);
         glog.push_back(gnt_o);
         gaps.push_back(idle_run);
         idle_run = 0;
      end else if (gnt_o == 2'b00) begin
         idle_run++;
      end
      prev_gnt = gnt_o;
      if (terms != 2'b00) begin
         if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_term: ack=%b err=%b rty=%b, expected none at %0t",
                     m_ack_o, m_err_o, m_rty_o, $time);
         end else begin
            e = sb.pop_front();
            check("m_ack_o", 64'(m_ack_o), 64'(e.ack));
            check("m_err_o", 64'(m_err_o), 64'(e.err));
            check("m_rty_o", 64'(m_rty_o), 64'h0);
            check("gnt_o", 64'(gnt_o), 64'(e.gnt));
            check("s_adr_o", 64'(s_adr_o), 64'(e.adr));
            check("m_dat_o", 64'(m_dat_o), 64'(e.rdat));
            check("s_cti_o", 64'(s_cti_o), 64'(e.cti));
            check("s_sel_o", 64'(s_sel_o), 64'(e.sel));
            check("s_stb_o", 64'(s_stb_o), 64'(e.stb));
            check("s_we_o", 64'(s_we_o), 64'(e.we));
            check("s_bte_o", 64'(s_bte_o), 64'h0);
            if (e.we) check("s_dat_o", 64'(s_dat_o), 64'(e.wdat));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         cyc_m[i] = 1'b0; stb_m[i] = 1'b0; we_m[i] = 1'b0;
         adr_m[i] = 32'h0; wdat_m[i] = 32'h0; cti_m[i] = 3'b000;
      end
      // Reset overrides a pending request.
      cyc_m[0] = 1'b1; stb_m[0] = 1'b1; we_m[0] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", 64'(gnt_o), 64'h0);
      check("rst_s_cyc", 64'(s_cyc_o), 64'h0);
      check("rst_s_stb", 64'(s_stb_o), 64'h0);
      check("rst_s_we", 64'(s_we_o), 64'h0);
      check("rst_terms", 64'(m_ack_o | m_err_o | m_rty_o), 64'h0);
      cyc_m[0] = 1'b0; stb_m[0] = 1'b0; we_m[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: classic read by master 0.
      cyc_m[0] = 1'b1; stb_m[0] = 1'b1; adr_m[0] = 32'h100; rd_data = 32'hDEADBEEF;
      @(negedge clk);
      check("t1_cyc_latency", 64'(s_cyc_o), 64'h0);
      @(posedge clk); #1;
      check("t1_gnt", 64'(gnt_o), 64'h1);
      check("t1_s_cyc", 64'(s_cyc_o), 64'h1);
      check("t1_s_adr", 64'(s_adr_o), 64'h100);
      push(1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      cyc_m[0] = 1'b0; stb_m[0] = 1'b0;
      #1;
      check("t1_cyc_comb_drop", 64'(s_cyc_o), 64'h0);
      check("t1_gnt_held", 64'(gnt_o), 64'h1);
      @(posedge clk); #1;
      check("t1_gnt_release", 64'(gnt_o), 64'h0);

      // 2: both masters alternate 3-write cycles.
      glog.delete(); gaps.delete();
      fork
         begin
            run_cycle(1'b0, 3, 32'h200, 1'b1, 1'b0, 32'h1111_0000);
            run_cycle(1'b0, 3, 32'h300, 1'b1, 1'b0, 32'h1111_1000);
         end
         begin
            @(posedge clk); #1;
            run_cycle(1'b1, 3, 32'h280, 1'b1, 1'b0, 32'h2222_0000);
            run_cycle(1'b1, 3, 32'h380, 1'b1, 1'b0, 32'h2222_1000);
         end
      join
      check("t2_grant_count", 64'(glog.size()), 64'd4);
      if (glog.size() == 4) begin
         check("t2_grant0", 64'(glog[0]), 64'h1);
         check("t2_grant1", 64'(glog[1]), 64'h2);
         check("t2_grant2", 64'(glog[2]), 64'h1);
         check("t2_grant3", 64'(glog[3]), 64'h2);
         for (int i = 1; i < 4; i++) check("t2_idle_gap", 64'(gaps[i]), 64'd1);
      end

      // 3: 8-beat incrementing burst by master 0 while master 1 waits.
      fork
         begin
            run_cycle(1'b0, 8, 32'h1000, 1'b0, 1'b1, 32'h3333_0000);
            check("t3_idle_after_burst", 64'(gnt_o), 64'h0);
            @(posedge clk); #1;
            check("t3_m1_granted", 64'(gnt_o), 64'h2);
         end
         begin
            @(posedge clk); #1;
            run_cycle(1'b1, 1, 32'h2000, 1'b0, 1'b0, 32'h4444_0000);
         end
      join

      // 4: watchdog timeout, late ack discarded in ABORT.
      fork
         begin
            ack_en = 1'b0;
            rd_data = 32'h0BAD_0400;
            cyc_m[0] = 1'b1; stb_m[0] = 1'b1; we_m[0] = 1'b0;
            adr_m[0] = 32'h400; cti_m[0] = 3'b000;
            wait_gnt(1'b0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("t4_no_err_early", 64'(m_err_o), 64'h0);
            push(1'b0, 32'h400, 32'h0BAD_0400, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
            @(posedge clk);
            @(negedge clk);
            check("t4_err_pulse", 64'(m_err_o), 64'h1);
            check("t4_stb_forced_low", 64'(s_stb_o), 64'h0);
            @(posedge clk); #1;
            force_ack = 1'b1;
            @(negedge clk);
            check("t4_late_ack_dropped", 64'(m_ack_o), 64'h0);
            check("t4_abort_cyc", 64'(s_cyc_o), 64'h0);
            check("t4_abort_gnt", 64'(gnt_o), 64'h1);
            @(posedge clk); #1;
            force_ack = 1'b0; ack_en = 1'b1;
            cyc_m[0] = 1'b0; stb_m[0] = 1'b0;
            @(posedge clk); #1;
            check("t4_idle_after_abort", 64'(gnt_o), 64'h0);
            @(posedge clk); #1;
            check("t4_m1_granted", 64'(gnt_o), 64'h2);
         end
         begin
            int t = 0;
            while (gnt_o[0] !== 1'b1 && t < 100) begin
               @(posedge clk); #1;
               t++;
            end
            run_cycle(1'b1, 1, 32'h4400, 1'b0, 1'b0, 32'h5555_0000);
         end
      join

      // 5: reset mid-burst, then master 0 regains first priority.
      cyc_m[0] = 1'b1; stb_m[0] = 1'b1; adr_m[0] = 32'h800; cti_m[0] = 3'b010;
      wait_gnt(1'b0);
      for (int b = 0; b < 4; b++) begin
         adr_m[0] = 32'h800 + 32'(4 * b);
         rd_data  = 32'h6666_0000 + 32'(b);
         push(1'b0, adr_m[0], rd_data, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0);
         if (b == 3) rst_n = 1'b0;
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      stb_m[0] = 1'b0;
      cyc_m[1] = 1'b1; stb_m[1] = 1'b1; adr_m[1] = 32'h3000;
      @(negedge clk);
      check("t5_rst_cyc", 64'(s_cyc_o), 64'h0);
      check("t5_rst_gnt", 64'(gnt_o), 64'h0);
      check("t5_rst_no_err", 64'(m_err_o), 64'h0);
      @(posedge clk); #1;
      check("t5_m0_first", 64'(gnt_o), 64'h1);
      cyc_m[0] = 1'b0; cti_m[0] = 3'b000;
      run_cycle(1'b1, 1, 32'h3000, 1'b0, 1'b0, 32'h7777_0000);

      // 6: ack arriving in the timeout cycle wins.
      ack_en = 1'b0;
      rd_data = 32'h8888_0C00;
      cyc_m[0] = 1'b1; stb_m[0] = 1'b1; adr_m[0] = 32'hC00; cti_m[0] = 3'b000;
      wait_gnt(1'b0);
      repeat (4) @(posedge clk);
      #1;
      force_ack = 1'b1;
      push(1'b0, 32'hC00, 32'h8888_0C00, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("t6_no_err", 64'(m_err_o), 64'h0);
      check("t6_ack", 64'(m_ack_o), 64'h1);
      @(posedge clk); #1;
      force_ack = 1'b0; ack_en = 1'b1;
      adr_m[0] = 32'hC04; rd_data = 32'h8888_0C04;
      push(1'b0, 32'hC04, 32'h8888_0C04, 32'h0, 3'b000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("t6_continues_busy", 64'(m_ack_o), 64'h1);
      @(posedge clk); #1;
      cyc_m[0] = 1'b0; stb_m[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(sb.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_avalon_arbiter.md
Name: wb_avalon_arbiter

Overview:
- Shares the single Wishbone slave port of the Wishbone-to-Avalon bridge between NUM_MASTERS Wishbone masters, e.g. the CPU instruction bus, the CPU data bus and a debug master.
- Uses round-robin arbitration, registered with one cycle of latency.
- Locks the grant for the whole cycle, cyc-to-cyc, so incrementing bursts and classic accesses reach the bridge unbroken.
- Has a per-beat watchdog that terminates a hung access with an error and drains the abandoned cycle.

Parameters:
- NUM_MASTERS, 2, number of requesting masters, range 2..8.
- DW, 32, data width.
- AW, 32, address width.
- TIMEOUT, 1023, cycles a strobed beat may wait for termination before error; 0 disables the watchdog; maximum 65535.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  synchronous active-low reset.
- m_adr_i  in  NUM_MASTERS*AW  packed master addresses; master i occupies bits [i*AW +: AW].
- m_dat_i  in  NUM_MASTERS*DW  packed write data.
- m_sel_i  in  NUM_MASTERS*DW/8  packed byte selects.
- m_we_i  in  NUM_MASTERS  write enables.
- m_cyc_i  in  NUM_MASTERS  cycle requests.
- m_stb_i  in  NUM_MASTERS  strobes.
- m_cti_i  in  NUM_MASTERS*3  packed cycle type.
- m_bte_i  in  NUM_MASTERS*2  packed burst type.
- m_dat_o  out  DW  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master err.
- m_rty_o  out  NUM_MASTERS  per-master rty.
- s_adr_o  out  AW  address to bridge.
- s_dat_o  out  DW  write data to bridge.
- s_sel_o  out  DW/8  byte selects.
- s_we_o  out  1  write enable.
- s_cyc_o  out  1  cycle.
- s_stb_o  out  1  strobe.
- s_cti_o  out  3  cycle type.
- s_bte_o  out  2  burst type.
- s_dat_i  in  DW  read data from bridge.
- s_ack_i  in  1  ack from bridge.
- s_err_i  in  1  err from bridge.
- s_rty_i  in  1  rty from bridge.
- gnt_o  out  NUM_MASTERS  registered one-hot grant; all zero when no master is granted.

Behaviour:

Reset:
- Applies when wb_rst_ni is low at a clock edge. Reset overrides all other logic.
- state=IDLE, gnt_o=0, last=NUM_MASTERS-1 (master 0 wins first), wd_cnt=0.
- s_cyc_o=s_stb_o=s_we_o=0; all m_ack_o, m_err_o and m_rty_o are 0.
- A reset during an active cycle drops s_cyc_o on the next cycle with no err.

State IDLE:
- s_cyc_o=0, s_stb_o=0, no terminations are forwarded.
- If any m_cyc_i is high, the winner is the first requester searched from (last+1) mod NUM_MASTERS upward, wrapping.
- On that edge: owner<=winner, gnt_o<=onehot(winner), state<=BUSY.
- Arbitration latency is one cycle: a request in cycle N is first seen on s_* in cycle N+1.

State BUSY:
- s_adr/dat/sel/we/cti/bte/cyc/stb_o are the owner's inputs, combinationally muxed.
- m_ack_o[owner]=s_ack_i, m_err_o[owner]=s_err_i, m_rty_o[owner]=s_rty_i; all other masters' terminations are 0.
- m_dat_o=s_dat_i in every state.
- Owner m_cyc_i low releases the bus:
  - s_cyc_o falls in the same cycle, because it is combinational.
  - Next edge: state<=IDLE, last<=owner, gnt_o<=0.
  - One idle cycle always separates two grants, even when other masters are waiting.
- Requests from non-owners are ignored and must be held by those masters.

Watchdog, BUSY only, TIMEOUT!=0:
- wd_cnt is 16 bits. It increments each cycle s_stb_o=1 and s_ack_i=s_err_i=s_rty_i=0, and clears on any termination or on s_stb_o=0.
- When wd_cnt==TIMEOUT in a cycle:
  - m_err_o[owner]=1 for that single cycle and s_stb_o is forced to 0.
  - Next edge: state<=ABORT, wd_cnt<=0.
- If the owner drops m_cyc_i in the same cycle as the timeout, release wins: no err, go to IDLE.
- If s_ack_i arrives in the timeout cycle, the ack wins: it is forwarded, no err is raised, and wd_cnt clears.

State ABORT:
- s_cyc_o=s_stb_o=0.
- Late s_ack_i/s_err_i/s_rty_i (for example a pending Avalon readdatavalid) are discarded; no terminations are forwarded.
- The owner stays granted until it drops m_cyc_i; then state<=IDLE and last<=owner.

Invariants:
- At most one bit of m_ack_o|m_err_o|m_rty_o is set.
- gnt_o is one-hot or zero.
- s_stb_o implies s_cyc_o.

Test Plan:
1. Reset, then only m_cyc_i[0] with a classic read at adr 0x100 -> s_cyc_o rises 1 cycle later; s_adr_o=0x100; s_ack_i with s_dat_i=0xDEADBEEF gives m_ack_o=2'b01 and m_dat_o=0xDEADBEEF; gnt_o=01 then 00 after cyc drops.
2. Both masters hold cyc continuously, each issuing 3 single writes per cycle -> grants alternate 0,1,0,1 with exactly one idle cycle between; m_ack_o[1] is never set while gnt_o=01.
3. Master 0 issues an 8-beat incrementing burst (cti=010, final 111) while master 1 requests throughout -> all 8 beats forwarded contiguously; gnt_o stays 01 until master 0 drops cyc; master 1 is granted 2 cycles later.
4. TIMEOUT=4, bridge never acks a read -> m_err_o[owner] pulses once after 4 stalled cycles with s_stb_o=0; a late s_ack_i in ABORT is not forwarded; other master is granted after owner drops cyc.
5. wb_rst_ni low for one cycle mid-burst -> next cycle s_cyc_o=0, gnt_o=0, no m_err_o; after release master 0 has first priority.
6. Timeout cycle coincides with s_ack_i -> ack forwarded, no err, transfer continues in BUSY.
